// File: rtl/pc_pkg.sv
// Shared MIPS package: architecture width, PC FSM state encoding and PC reset value.
package pc_pkg;

    // Architecture data/address width
    localparam int ARCH_WIDTH = 32;

    // PC FSM state type and encoding
    typedef logic [0:0] pc_state_t;
    localparam logic [0:0] ST_RUNNING = 1'b0;
    localparam logic [0:0] ST_HALTED  = 1'b1;

    // Value the PC takes on reset and on flush
    localparam logic [ARCH_WIDTH-1:0] PC_RESET_VALUE = 32'h0000_0000;

endpackage : pc_pkg

// File: rtl/pc.sv
// Program counter with RUNNING/HALTED control FSM.
// Priority per edge: reset > disabled > flush > clear > halt > stall > load.
// o_pc comes straight from the PC register, so there is no input-to-output path.
module pc
    import pc_pkg::*;
#(
    parameter int PC_SIZE = ARCH_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_flush,
    input  logic               i_clear,
    input  logic               i_halt,
    input  logic               i_not_load,
    input  logic               i_enable,
    input  logic [PC_SIZE-1:0] i_next_pc,
    output logic [PC_SIZE-1:0] o_pc
);

    localparam logic [PC_SIZE-1:0] PC_INIT = PC_SIZE'(PC_RESET_VALUE);

    pc_state_t          state_r;
    pc_state_t          state_next_s;
    logic [PC_SIZE-1:0] pc_r;
    logic [PC_SIZE-1:0] pc_next_s;

    // Next-state and next-PC selection in priority order
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        if (!i_enable) begin
            // frozen: everything holds, control pulses ignored
            state_next_s = state_r;
            pc_next_s    = pc_r;
        end else if (i_flush) begin
            state_next_s = ST_RUNNING;
            pc_next_s    = PC_INIT;
        end else if (i_clear) begin
            // leave HALTED but do not load on the same edge
            state_next_s = ST_RUNNING;
            pc_next_s    = pc_r;
        end else if (i_halt) begin
            state_next_s = ST_HALTED;
            pc_next_s    = pc_r;
        end else begin
            case (state_r)
                ST_RUNNING: begin
                    state_next_s = ST_RUNNING;
                    if (i_not_load) begin
                        pc_next_s = pc_r;
                    end else begin
                        pc_next_s = i_next_pc;
                    end
                end
                ST_HALTED: begin
                    state_next_s = ST_HALTED;
                    pc_next_s    = pc_r;
                end
                default: begin
                    // unreachable encoding: recover to a known state, keep PC
                    state_next_s = ST_RUNNING;
                    pc_next_s    = pc_r;
                end
            endcase
        end
    end

    // State and PC registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= ST_RUNNING;
            pc_r    <= PC_INIT;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
        end
    end

    assign o_pc = pc_r;

endmodule : pc

// File: tb/tb_pc.sv
// Directed self-checking testbench for the pc block.
module tb_pc;

    logic        clk;
    logic        i_reset;
    logic        i_flush;
    logic        i_clear;
    logic        i_halt;
    logic        i_not_load;
    logic        i_enable;
    logic [31:0] i_next_pc;
    logic [31:0] o_pc;

    int checks_cnt = 0;
    int errors_cnt = 0;

    pc #(.PC_SIZE(32)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_flush    (i_flush),
        .i_clear    (i_clear),
        .i_halt     (i_halt),
        .i_not_load (i_not_load),
        .i_enable   (i_enable),
        .i_next_pc  (i_next_pc),
        .o_pc       (o_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    // advance one rising edge, then step away from it before sampling/driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        i_reset    = 1'b1;
        i_flush    = 1'b0;
        i_clear    = 1'b0;
        i_halt     = 1'b0;
        i_not_load = 1'b0;
        i_enable   = 1'b0;
        i_next_pc  = 32'd0;
        tick();
        tick();
        check_val("reset", o_pc, 32'd0);
        i_reset = 1'b0;

        // load 1..10
        i_enable = 1'b1;
        for (int v = 1; v <= 10; v++) begin
            i_next_pc = 32'(v);
            tick();
            check_val($sformatf("load_%0d", v), o_pc, 32'(v));
        end

        // disabled: steps 11..20 with flush/halt pulses ignored
        i_enable = 1'b0;
        for (int v = 11; v <= 20; v++) begin
            i_next_pc = 32'(v);
            i_flush   = (v == 13);
            i_halt    = (v == 16);
            tick();
            check_val($sformatf("disabled_%0d", v), o_pc, 32'd10);
        end
        i_flush  = 1'b0;
        i_halt   = 1'b0;
        i_enable = 1'b1;

        // ignored halt must not have stuck: load resumes
        i_next_pc = 32'd11;
        tick();
        check_val("after_disable", o_pc, 32'd11);
        i_next_pc = 32'd10;
        tick();
        check_val("back_to_10", o_pc, 32'd10);

        // halt pulse is sticky
        i_halt    = 1'b1;
        i_next_pc = 32'd25;
        tick();
        check_val("halt_edge", o_pc, 32'd10);
        i_halt = 1'b0;
        tick();
        check_val("halt_sticky", o_pc, 32'd10);
        i_not_load = 1'b0;
        tick();
        check_val("halt_sticky2", o_pc, 32'd10);

        // clear: holds on its edge, loads on the next
        i_clear   = 1'b1;
        i_next_pc = 32'd35;
        tick();
        check_val("clear_edge", o_pc, 32'd10);
        i_clear = 1'b0;
        tick();
        check_val("after_clear", o_pc, 32'd35);

        // stall
        i_not_load = 1'b1;
        for (int v = 36; v <= 40; v++) begin
            i_next_pc = 32'(v);
            tick();
            check_val($sformatf("stall_%0d", v), o_pc, 32'd35);
        end
        i_not_load = 1'b0;
        i_next_pc  = 32'd45;
        tick();
        check_val("unstall", o_pc, 32'd45);

        // halted then flush
        i_halt    = 1'b1;
        i_next_pc = 32'd50;
        tick();
        check_val("halt_at_45", o_pc, 32'd45);
        i_halt = 1'b0;
        tick();
        check_val("halted_45", o_pc, 32'd45);
        i_flush = 1'b1;
        tick();
        check_val("flush", o_pc, 32'd0);
        i_flush   = 1'b0;
        i_next_pc = 32'd60;
        tick();
        check_val("after_flush", o_pc, 32'd60);

        // reset wins over enable=0
        i_enable = 1'b0;
        i_reset  = 1'b1;
        tick();
        check_val("reset_disabled", o_pc, 32'd0);
        i_reset   = 1'b0;
        i_enable  = 1'b1;
        i_next_pc = 32'd70;
        tick();
        check_val("after_reset", o_pc, 32'd70);

        // halt + clear together: clear wins, PC holds, stays running
        i_halt    = 1'b1;
        i_clear   = 1'b1;
        i_next_pc = 32'd80;
        tick();
        check_val("halt_clear", o_pc, 32'd70);
        i_halt    = 1'b0;
        i_clear   = 1'b0;
        i_next_pc = 32'd81;
        tick();
        check_val("still_running", o_pc, 32'd81);

        // flush + stall together
        i_flush    = 1'b1;
        i_not_load = 1'b1;
        tick();
        check_val("flush_stall", o_pc, 32'd0);
        i_flush    = 1'b0;
        i_not_load = 1'b0;
        i_next_pc  = 32'd90;
        tick();
        check_val("after_flush_stall", o_pc, 32'd90);

        // reset while halted
        i_halt = 1'b1;
        tick();
        check_val("halt_at_90", o_pc, 32'd90);
        i_halt  = 1'b0;
        i_reset = 1'b1;
        tick();
        check_val("reset_halted", o_pc, 32'd0);
        i_reset   = 1'b0;
        i_next_pc = 32'd95;
        tick();
        check_val("load_after_reset", o_pc, 32'd95);

        // verbatim load of an unaligned, wide value
        i_next_pc = 32'hFFFF_FFFD;
        tick();
        check_val("verbatim", o_pc, 32'hFFFF_FFFD);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule : tb_pc

// File: doc/pc.md
PC -- requirements
Module: pc

Interface
REQ-001 Parameter PC_SIZE, default 32, width of the program counter and of i_next_pc/o_pc.
REQ-002 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 i_reset  input  1  reset, synchronous and active-high.
REQ-004 i_flush  input  1  synchronous flush: PC to 0, leave HALTED.
REQ-005 i_clear  input  1  clear halt: HALTED back to RUNNING, PC kept.
REQ-006 i_halt  input  1  halt request; sticky until cleared.
REQ-007 i_not_load  input  1  stall: hold PC for this cycle.
REQ-008 i_enable  input  1  global enable; 0 freezes all state.
REQ-009 i_next_pc  input  PC_SIZE  next PC value to load.
REQ-010 o_pc  output  PC_SIZE  current PC, driven directly from the PC register.

Function
REQ-011 Two-state FSM: RUNNING and HALTED; the PC register is PC_SIZE bits wide.
REQ-012 Per-edge priority: i_reset > i_enable=0 > i_flush > i_clear > i_halt > i_not_load > load.
REQ-013 i_enable=0: PC and FSM state hold; i_flush/i_clear/i_halt are ignored.
REQ-014 i_flush=1 (enabled): PC <= 0, state <= RUNNING.
REQ-015 i_clear=1 (enabled, no flush): state <= RUNNING, PC holds this cycle.
REQ-016 i_halt=1 (enabled, no flush/clear): state <= HALTED, PC holds; dropping i_halt does not leave HALTED.
REQ-017 HALTED: PC holds regardless of i_next_pc or i_not_load until i_flush, i_clear or i_reset.
REQ-018 RUNNING, enabled, i_not_load=1: PC holds.
REQ-019 RUNNING, enabled, i_not_load=0: PC <= i_next_pc; o_pc shows the value one edge after it is sampled (latency 1).
REQ-020 i_next_pc is loaded verbatim; no increment, no alignment, no width extension.
REQ-021 No combinational path from any input to o_pc.

Reset
REQ-022 i_reset=1 at an edge: PC <= 0, state <= RUNNING, regardless of i_enable or any other input.
REQ-023 Reset mid-HALTED or mid-stall takes effect on that edge; the first load occurs on the first enabled edge after reset deasserts.

Structure
REQ-024 State encoding (RUNNING/HALTED) and the reset PC value (0) live in the shared MIPS package; default PC_SIZE matches the package's architecture width (32).
REQ-025 Single flat module, no sub-modules; next-state logic and register in separate blocks.

Verification
REQ-026 Reset, enable=1, i_next_pc stepped 1..10 one per cycle -> o_pc=10 one edge after the last step.
REQ-027 enable=0, i_next_pc stepped 11..20 -> o_pc stays 10; flush/halt pulses during this window have no effect.
REQ-028 enable=1, one-cycle i_halt pulse, i_next_pc stepped to 25 -> o_pc stays 10; i_clear pulse, i_next_pc=35 -> o_pc=35 next edge.
REQ-029 i_not_load=1, i_next_pc stepped 36..40 -> o_pc stays 35; i_not_load=0, i_next_pc=45 -> o_pc=45.
REQ-030 HALTED with o_pc=45, i_flush pulse -> o_pc=0 next edge, then loads resume; i_reset asserted with enable=0 -> o_pc=0.
REQ-031 Simultaneous i_halt and i_clear -> stays RUNNING and PC holds; simultaneous i_flush and i_not_load -> o_pc=0.
